// File: rtl/enc3_scheduler.sv
// -----------------------------------------------------------------------------
// enc3_scheduler
//
// Purpose:
//   Front-end scheduler for the shared encrypt_function_3 datapath. Two
//   plaintext requesters are arbitrated round-robin. The winning 60-bit word
//   and two random operands taken from an internal 17-bit LFSR are presented
//   to the datapath. The scheduler waits out the datapath's one-cycle
//   registered latency, captures the 78-bit ciphertext, and holds it with the
//   source requester ID until the consumer accepts it.
//
// Ports:
//   Clk, Rst               clock; synchronous active-high reset
//   req0_valid/data/ready  requester 0 handshake (60-bit plaintext)
//   req1_valid/data/ready  requester 1 handshake (60-bit plaintext)
//   enc_data/rand_11/rand_6  operands driven to the datapath
//   enc_out                datapath result (78 bits, bit 77 = sum carry)
//   out_valid/ready        result handshake
//   out_word/out_id        ciphertext and the requester it came from
//   busy                   high whenever the FSM is not idle
//   err                    sticky self-check flag
//
// Configuration:
//   ENC3_SCHED_CHECK_EN    when defined, the low 17 bits of the datapath result
//                          are compared against the issued random operands in
//                          CAPTURE. A mismatch sets err until reset, and the
//                          word is still forwarded. When undefined, err is tied
//                          low and no compare logic is built.
// -----------------------------------------------------------------------------
module enc3_scheduler #(
  parameter logic [16:0] SEED = 17'h1ACE5
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        req0_valid,
  input  logic [59:0] req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [59:0] req1_data,
  output logic        req1_ready,
  output logic [59:0] enc_data,
  output logic [10:0] enc_rand_11,
  output logic [5:0]  enc_rand_6,
  input  logic [77:0] enc_out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [77:0] out_word,
  output logic        out_id,
  output logic        busy,
  output logic        err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_CAPTURE,
    S_HOLD
  } state_t;

  // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
  localparam logic [16:0] LFSR_INIT = (SEED == 17'd0) ? 17'h00001 : SEED;

  state_t      r_state;
  logic [16:0] r_lfsr;
  logic        r_last_id;
  logic [59:0] r_enc_data;
  logic [10:0] r_enc_rand_11;
  logic [5:0]  r_enc_rand_6;
  logic [77:0] r_out_word;
  logic        r_out_id;
  logic        r_out_valid;

  logic        w_any_valid;
  logic        w_grant_id;
  logic        w_accept;
  logic [16:0] w_lfsr_next;

  // Round-robin grant. A lone requester always wins. On a tie, the requester
  // that did not win last time gets the grant.
  assign w_any_valid = req0_valid | req1_valid;
  assign w_grant_id  = (req0_valid & req1_valid) ? ~r_last_id : req1_valid;
  assign w_accept    = (r_state == S_IDLE) & w_any_valid;

  // A ready is raised only toward the granted requester, so a ready that is
  // high always means the request is accepted on this edge.
  assign req0_ready  = w_accept & ~w_grant_id;
  assign req1_ready  = w_accept &  w_grant_id;

  // Fibonacci LFSR, x^17 + x^14 + 1.
  assign w_lfsr_next = {r_lfsr[15:0], r_lfsr[16] ^ r_lfsr[13]};

  // NOTE: every state register below is assigned with <= so all of them
  // update together from pre-edge values. A blocking assignment here would
  // let later statements in the block see half-updated state.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state       <= S_IDLE;
      r_lfsr        <= LFSR_INIT;
      r_last_id     <= 1'b1;
      r_enc_data    <= '0;
      r_enc_rand_11 <= '0;
      r_enc_rand_6  <= '0;
      r_out_word    <= '0;
      r_out_id      <= 1'b0;
      r_out_valid   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_enc_data    <= w_grant_id ? req1_data : req0_data;
            r_out_id      <= w_grant_id;
            r_last_id     <= w_grant_id;
            r_enc_rand_11 <= r_lfsr[16:6];
            r_enc_rand_6  <= r_lfsr[5:0];
            r_lfsr        <= w_lfsr_next;
            r_state       <= S_ISSUE;
          end
        end
        // The datapath registers the operands at the end of this cycle.
        S_ISSUE: begin
          r_state <= S_CAPTURE;
        end
        S_CAPTURE: begin
          r_out_word  <= enc_out;
          r_out_valid <= 1'b1;
          r_state     <= S_HOLD;
        end
        S_HOLD: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef ENC3_SCHED_CHECK_EN
  logic r_err;

  // The datapath passes the random operands through in its low 17 bits, so
  // a difference there means the datapath or its wiring is faulty.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_err <= 1'b0;
    end else if ((r_state == S_CAPTURE) &&
                 (enc_out[16:0] != {r_enc_rand_11, r_enc_rand_6})) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  assign enc_data    = r_enc_data;
  assign enc_rand_11 = r_enc_rand_11;
  assign enc_rand_6  = r_enc_rand_6;
  assign out_word    = r_out_word;
  assign out_id      = r_out_id;
  assign out_valid   = r_out_valid;
  assign busy        = (r_state != S_IDLE);

endmodule
